// File: rtl/osd_dem_uart_arbiter.sv
// Line-aware round-robin arbiter merging NUM_SRC character streams into one debug UART input.
// One IDLE cycle per grant, then zero-latency pass-through; out_ready stalls only the granted source.
module osd_dem_uart_arbiter #(
   parameter int NUM_SRC   = 4,
   parameter int LINE_LOCK = 1,
   parameter int TIMEOUT   = 255,
   parameter int SRC_W     = $clog2(NUM_SRC)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_SRC*8-1:0] src_char,
   input  logic [NUM_SRC-1:0]   src_valid,
   output logic [NUM_SRC-1:0]   src_ready,
   output logic [7:0]           out_char,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SRC_W-1:0]     grant_id,
   output logic                 locked
);

   localparam int         TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [7:0] LF    = 8'h0A;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t             state, state_nxt;
   logic [SRC_W-1:0]   rr_ptr, rr_ptr_nxt;
   logic [SRC_W-1:0]   grant, grant_nxt;
   logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_nxt;

   logic [7:0]         g_char;
   logic               g_valid;
   logic [SRC_W-1:0]   grant_inc;

   logic [2*NUM_SRC-1:0] req_dbl;
   logic [NUM_SRC-1:0]   req_rot;
   logic [SRC_W-1:0]     rot_off;
   logic [SRC_W:0]       pick_sum;
   logic [SRC_W-1:0]     pick;
   logic                 any_req;

   logic xfer, eol, stall, expire;

   // View of the currently granted source
   always_comb begin
      g_char  = '0;
      g_valid = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant == SRC_W'(i)) begin
            g_char  = src_char[i*8 +: 8];
            g_valid = src_valid[i];
         end
      end
   end

   assign grant_inc = (grant == SRC_W'(NUM_SRC - 1)) ? '0 : grant + SRC_W'(1);

   // Rotate requests so bit 0 is rr_ptr, then take the lowest set bit
   assign req_dbl = {src_valid, src_valid} >> rr_ptr;
   assign req_rot = req_dbl[NUM_SRC-1:0];
   assign any_req = |src_valid;

   always_comb begin
      rot_off = '0;
      for (int j = NUM_SRC - 1; j >= 0; j--) begin
         if (req_rot[j]) rot_off = SRC_W'(j);
      end
   end

   assign pick_sum = {1'b0, rr_ptr} + {1'b0, rot_off};
   assign pick     = (pick_sum >= (SRC_W+1)'(NUM_SRC))
                   ? SRC_W'(pick_sum - (SRC_W+1)'(NUM_SRC))
                   : pick_sum[SRC_W-1:0];

   assign xfer   = (state == LOCKED) && g_valid && out_ready;
   assign eol    = (LINE_LOCK == 0) || (g_char == LF);
   assign stall  = !g_valid;
   assign expire = (TIMEOUT != 0) && stall && (tmo_cnt == TMO_W'(TIMEOUT - 1));

   always_comb begin
      state_nxt   = state;
      rr_ptr_nxt  = rr_ptr;
      grant_nxt   = grant;
      tmo_cnt_nxt = tmo_cnt;
      case (state)
         IDLE: begin
            if (any_req) begin
               grant_nxt   = pick;
               state_nxt   = LOCKED;
               tmo_cnt_nxt = '0;
            end
         end
         LOCKED: begin
            if (xfer) begin
               tmo_cnt_nxt = '0;
               if (eol) begin
                  state_nxt  = IDLE;
                  rr_ptr_nxt = grant_inc;
               end
            end else if (stall) begin
               if (expire) begin
                  state_nxt   = IDLE;
                  rr_ptr_nxt  = grant_inc;
                  tmo_cnt_nxt = '0;
               end else if (TIMEOUT != 0) begin
                  tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
               end
            end
            // valid but backpressured: counter holds
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         grant   <= '0;
         tmo_cnt <= '0;
      end else begin
         state   <= state_nxt;
         rr_ptr  <= rr_ptr_nxt;
         grant   <= grant_nxt;
         tmo_cnt <= tmo_cnt_nxt;
      end
   end

   // Everything visible is forced quiet while reset is asserted
   always_comb begin
      out_char  = '0;
      out_valid = 1'b0;
      src_ready = '0;
      locked    = 1'b0;
      grant_id  = rst_n ? grant : '0;
      if (rst_n && (state == LOCKED)) begin
         out_char  = g_char;
         out_valid = g_valid;
         locked    = 1'b1;
         for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = (grant == SRC_W'(i)) && out_ready;
         end
      end
   end

endmodule

// File: tb/tb_osd_dem_uart_arbiter.sv
// Directed bench: DUT a (line lock, 8-cycle timeout) and DUT b (per-character release).
module tb_osd_dem_uart_arbiter;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [N*8-1:0] a_char,  b_char;
   logic [N-1:0]   a_valid, b_valid, a_ready, b_ready;
   logic [7:0]     a_out_char, b_out_char;
   logic           a_out_valid, b_out_valid, a_out_ready, b_out_ready;
   logic [1:0]     a_gid, b_gid;
   logic           a_locked, b_locked;

   osd_dem_uart_arbiter #(.NUM_SRC(N), .LINE_LOCK(1), .TIMEOUT(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .src_char(a_char), .src_valid(a_valid), .src_ready(a_ready),
      .out_char(a_out_char), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .grant_id(a_gid), .locked(a_locked));

   osd_dem_uart_arbiter #(.NUM_SRC(N), .LINE_LOCK(0), .TIMEOUT(255)) dut_b (
      .clk(clk), .rst_n(rst_n), .src_char(b_char), .src_valid(b_valid), .src_ready(b_ready),
      .out_char(b_out_char), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .grant_id(b_gid), .locked(b_locked));

   logic [7:0]  aq [N][$];
   logic [7:0]  bq [N][$];
   logic [11:0] a_sb [$];
   logic [11:0] b_sb [$];
   logic [N-1:0] hs_a, hs_b;
   int compared = 0;
   int mismatched = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic exp_a(input int s, input logic [7:0] c);
      a_sb.push_back({s[3:0], c});
   endtask

   task automatic exp_b(input int s, input logic [7:0] c);
      b_sb.push_back({s[3:0], c});
   endtask

   task automatic refresh();
      for (int i = 0; i < N; i++) begin
         a_valid[i]        = (aq[i].size() > 0);
         a_char[i*8 +: 8]  = (aq[i].size() > 0) ? aq[i][0] : 8'h00;
         b_valid[i]        = (bq[i].size() > 0);
         b_char[i*8 +: 8]  = (bq[i].size() > 0) ? bq[i][0] : 8'h00;
      end
   endtask

   task automatic mon();
      logic [11:0] e;
      if (a_out_valid && a_out_ready) begin
         chk("a_sb_pending", 32'(a_sb.size() != 0), 1);
         if (a_sb.size() != 0) begin
            e = a_sb.pop_front();
            chk("a_out_char", 32'(a_out_char), 32'(e[7:0]));
            chk("a_out_src", 32'(a_gid), 32'(e[11:8]));
         end
      end
      if (b_out_valid && b_out_ready) begin
         chk("b_sb_pending", 32'(b_sb.size() != 0), 1);
         if (b_sb.size() != 0) begin
            e = b_sb.pop_front();
            chk("b_out_char", 32'(b_out_char), 32'(e[7:0]));
            chk("b_out_src", 32'(b_gid), 32'(e[11:8]));
         end
      end
   endtask

   // One clock: score outputs, let the edge happen, retire accepted characters
   task automatic step();
      mon();
      hs_a = a_valid & a_ready;
      hs_b = b_valid & b_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (hs_a[i]) void'(aq[i].pop_front());
         if (hs_b[i]) void'(bq[i].pop_front());
      end
      refresh();
      @(negedge clk);
      #1;
   endtask

   task automatic run_a(input int budget);
      int n = 0;
      while (a_sb.size() > 0 && n < budget) begin
         step();
         n++;
      end
      chk("a_drain", 32'(a_sb.size()), 0);
   endtask

   initial begin
      int lk_tab [8]  = '{1, 1, 1, 0, 1, 1, 1, 0};
      int gid_tab [8] = '{0, 0, 0, 0, 2, 2, 2, 2};
      int rdy_tab [8] = '{1, 1, 1, 0, 4, 4, 4, 0};

      // Reset with every source requesting
      rst_n = 1'b0;
      a_out_ready = 1'b1;
      b_out_ready = 1'b1;
      a_valid = '1;
      a_char  = {N{8'h55}};
      b_valid = '0;
      b_char  = '0;
      hs_a = '0;
      hs_b = '0;
      @(negedge clk);
      #1;
      for (int c = 0; c < 3; c++) begin
         chk("rst_out_valid", 32'(a_out_valid), 0);
         chk("rst_src_ready", 32'(a_ready), 0);
         chk("rst_locked", 32'(a_locked), 0);
         chk("rst_grant_id", 32'(a_gid), 0);
         chk("rst_out_char", 32'(a_out_char), 0);
         @(negedge clk);
         #1;
      end

      // Line lock: src0 and src2 both send "AB\n"
      aq[0] = '{8'h41, 8'h42, 8'h0A};
      aq[2] = '{8'h41, 8'h42, 8'h0A};
      refresh();
      rst_n = 1'b1;
      #1;
      for (int s = 0; s < 3; s += 2) begin
         exp_a(s, 8'h41); exp_a(s, 8'h42); exp_a(s, 8'h0A);
      end
      chk("ll_idle_locked", 32'(a_locked), 0);
      step();
      for (int c = 0; c < 8; c++) begin
         chk("ll_locked", 32'(a_locked), 32'(lk_tab[c]));
         chk("ll_grant_id", 32'(a_gid), 32'(gid_tab[c]));
         chk("ll_src_ready", 32'(a_ready), 32'(rdy_tab[c]));
         step();
      end
      chk("ll_drained", 32'(a_sb.size()), 0);

      // Wrap: src3 line, then all four request -> 0,1,2,3
      aq[3] = '{8'h58, 8'h0A};
      refresh();
      exp_a(3, 8'h58); exp_a(3, 8'h0A);
      run_a(10);
      for (int s = 0; s < N; s++) begin
         aq[s] = '{8'h58, 8'h0A};
         exp_a(s, 8'h58); exp_a(s, 8'h0A);
      end
      refresh();
      run_a(40);

      // Timeout: src1 stalls after one char while src2 waits
      aq[1] = '{8'h41};
      aq[2] = '{8'h42, 8'h0A};
      refresh();
      exp_a(1, 8'h41); exp_a(2, 8'h42); exp_a(2, 8'h0A);
      chk("tmo_idle", 32'(a_locked), 0);
      step();
      chk("tmo_grant1", 32'(a_gid), 1);
      chk("tmo_out_valid", 32'(a_out_valid), 1);
      step();
      for (int c = 1; c <= 8; c++) begin
         chk("tmo_stall_locked", 32'(a_locked), 1);
         chk("tmo_stall_gid", 32'(a_gid), 1);
         step();
      end
      chk("tmo_revoked", 32'(a_locked), 0);
      step();
      chk("tmo_src2_locked", 32'(a_locked), 1);
      chk("tmo_src2_gid", 32'(a_gid), 2);
      run_a(10);
      aq[1] = '{8'h43, 8'h0A};
      refresh();
      exp_a(1, 8'h43); exp_a(1, 8'h0A);
      run_a(10);

      // Backpressure: 500 stalled cycles with src1 valid must not time out
      a_out_ready = 1'b0;
      aq[1] = '{8'h41, 8'h0A};
      refresh();
      exp_a(1, 8'h41); exp_a(1, 8'h0A);
      step();
      for (int c = 0; c < 500; c++) begin
         chk("bp_locked", 32'(a_locked), 1);
         chk("bp_out_char", 32'(a_out_char), 32'h41);
         step();
      end
      a_out_ready = 1'b1;
      #1;
      chk("bp_release_valid", 32'(a_out_valid), 1);
      chk("bp_release_ready", 32'(a_ready), 32'h2);
      run_a(10);

      // Per-character release on dut_b
      bq[0] = '{8'h61, 8'h62};
      bq[1] = '{8'h61, 8'h62};
      refresh();
      exp_b(0, 8'h61); exp_b(1, 8'h61); exp_b(0, 8'h62); exp_b(1, 8'h62);
      chk("nl_idle", 32'(b_locked), 0);
      for (int c = 0; c < 8; c++) begin
         step();
         chk("nl_locked", 32'(b_locked), 32'((c % 2) == 0));
         if ((c % 2) == 0) chk("nl_gid", 32'(b_gid), 32'((c / 2) % 2));
         else chk("nl_idle_valid", 32'(b_out_valid), 0);
      end
      chk("nl_drained", 32'(b_sb.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/osd_dem_uart_arbiter.md
Name: osd_dem_uart_arbiter

Overview:
- Line-aware round-robin arbiter that lets NUM_SRC character producers (e.g. per-core UART/printf streams) share the single character input of the UART debug module.
- Its out_char/out_valid/out_ready side connects directly to that module's character input.
- Grants are held until a line terminator is transferred, or until an idle timeout expires, so lines from different sources are not interleaved on the host side.
- grant_id tells software or a tagging stage which source owns the current line.

Parameters:
- NUM_SRC, 4: number of character sources; legal range 2..16.
- LINE_LOCK, 1: 1 = hold grant until 8'h0A is transferred; 0 = release after every character.
- TIMEOUT, 255: cycles the granted source may stall (src_valid low) before its grant is revoked; 0 disables the timeout.
- SRC_W, $clog2(NUM_SRC): derived width of grant_id; not to be overridden.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- src_char  input  NUM_SRC*8  source i character at bits [8i+7:8i].
- src_valid  input  NUM_SRC  per-source character valid.
- src_ready  output  NUM_SRC  per-source accept; at most one bit high per cycle.
- out_char  output  8  character to the UART debug module.
- out_valid  output  1  out_char valid.
- out_ready  input  1  downstream accept.
- grant_id  output  SRC_W  index of the currently/last granted source.
- locked  output  1  high while a grant is held.

Behaviour:
- **Handshake**: a transfer occurs on a rising clk edge where out_valid & out_ready. Source i transfers exactly when src_valid[i] & src_ready[i].
- **State register**: state ∈ {IDLE, LOCKED}. Other registers are rr_ptr (SRC_W bits), grant (SRC_W bits) and tmo_cnt (width $clog2(TIMEOUT+1), minimum 1 bit).
- **Reset** (rst_n=0 sampled at an edge): state=IDLE, rr_ptr=0, grant=0, tmo_cnt=0.
  - All outputs are gated with rst_n, so in any cycle with rst_n=0: out_valid=0, src_ready=0, locked=0, grant_id=0, out_char=0.
  - No handshake can complete during a reset cycle.
  - Reset mid-line drops the grant; the partially sent line is not resumed.
- **IDLE**:
  - out_valid=0, src_ready=0, out_char=0.
  - If any src_valid is set: select the first set bit searching rr_ptr, rr_ptr+1, … modulo NUM_SRC.
  - Next edge: grant=selected, state=LOCKED, tmo_cnt=0.
  - Arbitration latency is one cycle. No character passes in the IDLE cycle.
- **LOCKED**:
  - out_char=src_char[grant], out_valid=src_valid[grant], src_ready[grant]=out_ready, all other src_ready bits 0. This path is combinational with zero added latency.
  - locked=1; grant_id=grant. In IDLE, grant_id holds the last grant value.
- **Release on transfer**: the grant is released when a transfer occurs and either LINE_LOCK=0, or out_char==8'h0A.
  - Next edge: state=IDLE, rr_ptr=(grant+1) mod NUM_SRC.
- **Timeout** (TIMEOUT≠0):
  - In LOCKED, tmo_cnt increments each cycle src_valid[grant]=0 and resets to 0 on every transfer.
  - A cycle with src_valid[grant]=1 but out_ready=0 holds tmo_cnt; downstream backpressure never triggers a timeout.
  - When tmo_cnt==TIMEOUT-1 and src_valid[grant]=0: next edge state=IDLE, rr_ptr=(grant+1) mod NUM_SRC.
  - So the grant is revoked after exactly TIMEOUT consecutive stall cycles.
- **Simultaneous transfer and expiry**: impossible, since a transfer requires src_valid[grant]=1. A transfer always clears tmo_cnt.
- **Wrap-around**: rr_ptr wraps from NUM_SRC-1 to 0. A source granted last has lowest priority next round. A single active source is re-granted after one IDLE cycle per line.
- **Stability**: out_char and out_valid may change only per the source's own valid/data rules. The arbiter never switches grant while out_valid=1 and out_ready=0.

Test Plan:
- **Reset**: rst_n=0 for 3 cycles with all src_valid=1 → out_valid=0, src_ready=0, locked=0, grant_id=0 on every reset cycle; first grant goes to source 0 one cycle after rst_n=1.
- **Line lock**: sources 0 and 2 both continuously valid with "AB\n" (41,42,0A), out_ready=1 → out stream 41,42,0A from src0, one IDLE cycle, then 41,42,0A from src2; grant_id 0 then 2; src_ready[2]=0 throughout src0's line.
- **Round-robin wrap**: NUM_SRC=4; src3 sends "X\n", then all four valid → next grant order is 0,1,2,3.
- **Backpressure**: src1 granted, out_ready=0 for 500 cycles with src_valid[1]=1 → no timeout, locked stays 1, char 41 delivered on first out_ready=1 cycle.
- **Timeout**: TIMEOUT=8, src1 sends 41 then deasserts valid while src2 is valid → locked drops after exactly 8 stall cycles; src2 granted next cycle; a src1 restart later gets a new grant.
- **LINE_LOCK=0**: src0 and src1 continuously valid with 61,62 → output alternates 61(src0), 61(src1), 62(src0), 62(src1), with one IDLE cycle between characters.
